// File: rtl/hpm_counter_bank.sv
// hpm_counter_bank - hardware performance-monitor counter bank.
//
// NUM_COUNTERS counters of COUNTER_WIDTH bits. Each one counts a single event
// chosen from the core event bus. The bank owns these CSRs:
// mhpmcounter/h (0xB03+i, 0xB83+i), the user read-only mirrors (0xC03+i,
// 0xC83+i), mhpmevent (0x323+i) and mcountinhibit (0x320).
//
// Ports:
//   clk, rst       clock; synchronous active-high reset
//   events         per-cycle event pulses from the core
//   csr_addr       CSR address
//   csr_active     request valid, held high until ack
//   csr_write      1 = write, 0 = read
//   value_in       write data
//   value_out      read data, or the old value on a write (valid with ack)
//   ack            one-cycle response strobe
//   invalid_csr    unowned address or illegal access (valid with ack)
//   overflow_irq   OR over counters of (OF & OIE)

// Per-counter slice: event select, counter, overflow flag.
module hpm_counter_lane #(
  parameter int NUM_EVENTS    = 8,
  parameter int COUNTER_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_EVENTS-1:0] events,
  input  logic                  inhibit,
  input  logic                  wr_lo,
  input  logic                  wr_hi,
  input  logic                  wr_evt,
  input  logic [31:0]           wdata,
  output logic [31:0]           rd_lo,
  output logic [31:0]           rd_hi,
  output logic [31:0]           rd_evt,
  output logic                  irq_req
);
  localparam int UW = COUNTER_WIDTH - 32;

  logic [COUNTER_WIDTH-1:0] count_q;
  logic [7:0]               sel_q;
  logic                     oie_q;
  logic                     of_q;
  logic [255:0]             ev_ext;
  logic                     inc;
  logic                     ovf;

  // Bit 0 stays 0 so SEL=0 counts nothing; selects above NUM_EVENTS hit zeros.
  always_comb begin
    ev_ext = '0;
    ev_ext[NUM_EVENTS:1] = events;
  end

  // A software write to either half takes precedence over this cycle's event.
  assign inc = ev_ext[sel_q] & ~inhibit;
  assign ovf = inc & ~wr_lo & ~wr_hi & (&count_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      sel_q   <= '0;
      oie_q   <= 1'b0;
      of_q    <= 1'b0;
    end else begin
      if (wr_lo)
        count_q[31:0] <= wdata;
      else if (wr_hi)
        count_q[COUNTER_WIDTH-1:32] <= wdata[UW-1:0];
      else if (inc)
        count_q <= count_q + COUNTER_WIDTH'(1);

      if (wr_evt) begin
        sel_q <= wdata[7:0];
        oie_q <= wdata[30];
        of_q  <= wdata[31];
      end
      // Hardware overflow beats a simultaneous software clear of OF.
      if (ovf)
        of_q <= 1'b1;
    end
  end

  assign rd_lo   = count_q[31:0];
  assign rd_hi   = 32'(count_q[COUNTER_WIDTH-1:32]);
  assign rd_evt  = {of_q, oie_q, 22'd0, sel_q};
  assign irq_req = of_q & oie_q;
endmodule

module hpm_counter_bank #(
  parameter int NUM_COUNTERS  = 4,
  parameter int NUM_EVENTS    = 8,
  parameter int COUNTER_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_EVENTS-1:0] events,
  input  logic [11:0]           csr_addr,
  input  logic                  csr_active,
  input  logic                  csr_write,
  input  logic [31:0]           value_in,
  output logic [31:0]           value_out,
  output logic                  ack,
  output logic                  invalid_csr,
  output logic                  overflow_irq
);
  typedef enum logic [1:0] {IDLE = 2'd0, RESP = 2'd1, DONE = 2'd2} state_t;

  state_t state_q, state_d;

  logic [NUM_COUNTERS-1:0][31:0] rd_lo, rd_hi, rd_evt;
  logic [NUM_COUNTERS-1:0]       irq_req;
  logic [NUM_COUNTERS-1:0]       inh_q;
  logic [NUM_COUNTERS-1:0]       sel_lo, sel_hi, sel_evt;
  logic [NUM_COUNTERS-1:0]       wr_lo, wr_hi, wr_evt;
  logic                          sel_inh;
  logic                          dec_ok, read_only, illegal;
  logic [31:0]                   rd_val;
  logic                          take, do_wr;

  // Address decode and read mux.
  always_comb begin
    sel_lo    = '0;
    sel_hi    = '0;
    sel_evt   = '0;
    sel_inh   = 1'b0;
    dec_ok    = 1'b0;
    read_only = 1'b0;
    rd_val    = '0;
    if (csr_addr == 12'h320) begin
      sel_inh = 1'b1;
      dec_ok  = 1'b1;
      rd_val  = 32'(inh_q) << 3;
    end
    for (int i = 0; i < NUM_COUNTERS; i++) begin
      if (csr_addr == 12'hB03 + 12'(i)) begin
        sel_lo[i] = 1'b1; dec_ok = 1'b1; rd_val = rd_lo[i];
      end
      if (csr_addr == 12'hB83 + 12'(i)) begin
        sel_hi[i] = 1'b1; dec_ok = 1'b1; rd_val = rd_hi[i];
      end
      if (csr_addr == 12'hC03 + 12'(i)) begin
        read_only = 1'b1; dec_ok = 1'b1; rd_val = rd_lo[i];
      end
      if (csr_addr == 12'hC83 + 12'(i)) begin
        read_only = 1'b1; dec_ok = 1'b1; rd_val = rd_hi[i];
      end
      if (csr_addr == 12'h323 + 12'(i)) begin
        sel_evt[i] = 1'b1; dec_ok = 1'b1; rd_val = rd_evt[i];
      end
    end
  end

  assign illegal = ~dec_ok | (read_only & csr_write);
  assign take    = (state_q == IDLE) & csr_active;
  assign do_wr   = take & csr_write & ~illegal;
  assign wr_lo   = sel_lo  & {NUM_COUNTERS{do_wr}};
  assign wr_hi   = sel_hi  & {NUM_COUNTERS{do_wr}};
  assign wr_evt  = sel_evt & {NUM_COUNTERS{do_wr}};

  for (genvar g = 0; g < NUM_COUNTERS; g++) begin : g_lane
    hpm_counter_lane #(
      .NUM_EVENTS   (NUM_EVENTS),
      .COUNTER_WIDTH(COUNTER_WIDTH)
    ) u_lane (
      .clk    (clk),
      .rst    (rst),
      .events (events),
      .inhibit(inh_q[g]),
      .wr_lo  (wr_lo[g]),
      .wr_hi  (wr_hi[g]),
      .wr_evt (wr_evt[g]),
      .wdata  (value_in),
      .rd_lo  (rd_lo[g]),
      .rd_hi  (rd_hi[g]),
      .rd_evt (rd_evt[g]),
      .irq_req(irq_req[g])
    );
  end

  assign overflow_irq = |irq_req;

  // DONE waits for csr_active to drop so a held request runs only once.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (csr_active) state_d = RESP;
      RESP:    state_d = DONE;
      DONE:    if (!csr_active) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ack is registered off RESP, so a reset during RESP suppresses it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ack         <= 1'b0;
      value_out   <= '0;
      invalid_csr <= 1'b0;
      inh_q       <= '0;
    end else begin
      state_q <= state_d;
      ack     <= (state_q == RESP);
      if (take) begin
        value_out   <= illegal ? 32'd0 : rd_val;
        invalid_csr <= illegal;
      end
      if (do_wr && sel_inh)
        inh_q <= value_in[3 +: NUM_COUNTERS];
    end
  end
endmodule
